// File: rtl/avalon_msg_buffer_if.sv
// Avalon-ST message interface shared by avalon_msg_buffer and its neighbours.
// Handshake: a beat transfers on a rising edge where valid and rdy are both high.
interface avalon_st_if #(
  parameter int DATA_WIDTH_IN_BYTES = 16
);
  localparam int EW = (DATA_WIDTH_IN_BYTES > 1) ? $clog2(DATA_WIDTH_IN_BYTES) : 1;

  logic [8*DATA_WIDTH_IN_BYTES-1:0] data;
  logic                             valid;
  logic                             sop;
  logic                             eop;
  logic [EW-1:0]                    empty;
  logic                             rdy;

  modport master (output data, valid, sop, eop, empty, input rdy);
  modport slave  (input data, valid, sop, eop, empty, output rdy);
endinterface

// File: rtl/avalon_msg_buffer.sv
// Store-and-forward buffer: releases only complete messages and drops whole messages that do not fit.
// Define AVALON_MSG_BUFFER_STATS_EN to add saturating passed/dropped message counters.
module avalon_msg_buffer #(
  parameter int DATA_WIDTH_IN_BYTES = 16,
  parameter int DEPTH               = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  avalon_st_if.slave              in_msg,
  avalon_st_if.master             out_msg,
  output logic                    drop_indi,
  output logic [$clog2(DEPTH):0]  msg_count,
  output logic [1:0]              in_state
`ifdef AVALON_MSG_BUFFER_STATS_EN
  ,
  output logic [31:0]             msgs_passed_cnt,
  output logic [31:0]             msgs_dropped_cnt
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int DW = 8 * DATA_WIDTH_IN_BYTES;
  localparam int EW = (DATA_WIDTH_IN_BYTES > 1) ? $clog2(DATA_WIDTH_IN_BYTES) : 1;
  localparam logic [AW:0] FULL_FILL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_DROP  = 2'd2
  } state_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
    logic [EW-1:0] empty;
  } entry_t;

  entry_t      mem [DEPTH];
  entry_t      rd_entry;
  state_t      state;
  logic [AW:0] wr_ptr;
  logic [AW:0] commit_ptr;
  logic [AW:0] rd_ptr;
  logic [AW:0] base_ptr;

  logic in_fire;
  logic out_fire;
  logic start_beat;
  logic cont_beat;
  logic store_beat;
  logic full;
  logic wr_en;
  logic commit_now;
  logic read_eop;
  logic drop_now;

  assign in_msg.rdy = ~rst;
  assign in_fire    = in_msg.valid & ~rst;

  // A sop beat always (re)starts a message at commit_ptr, discarding any partial one.
  assign start_beat = in_fire & in_msg.sop;
  assign cont_beat  = in_fire & ~in_msg.sop & (state == S_WRITE);
  assign store_beat = start_beat | cont_beat;
  assign base_ptr   = start_beat ? commit_ptr : wr_ptr;
  assign full       = ((base_ptr - rd_ptr) == FULL_FILL);
  assign wr_en      = store_beat & ~full;
  assign commit_now = wr_en & in_msg.eop;
  assign drop_now   = (start_beat & (state == S_WRITE)) | (store_beat & full);

  assign rd_entry      = mem[rd_ptr[AW-1:0]];
  assign out_msg.valid = (rd_ptr != commit_ptr);
  assign out_msg.data  = rd_entry.data;
  assign out_msg.sop   = rd_entry.sop;
  assign out_msg.eop   = rd_entry.eop;
  assign out_msg.empty = rd_entry.empty;
  assign out_fire      = out_msg.valid & out_msg.rdy;
  assign read_eop      = out_fire & rd_entry.eop;

  assign in_state = state;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[base_ptr[AW-1:0]] <= '{data: in_msg.data, sop: in_msg.sop,
                                 eop: in_msg.eop, empty: in_msg.empty};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      wr_ptr     <= '0;
      commit_ptr <= '0;
      rd_ptr     <= '0;
      msg_count  <= '0;
      drop_indi  <= 1'b0;
    end else begin
      drop_indi <= drop_now;

      if (out_fire) begin
        rd_ptr <= rd_ptr + 1'b1;
      end

      if (commit_now && !read_eop) begin
        msg_count <= msg_count + 1'b1;
      end else if (!commit_now && read_eop) begin
        msg_count <= msg_count - 1'b1;
      end

      if (store_beat) begin
        if (full) begin
          // Rewind to the last complete message; an overflowing eop needs no drop phase.
          wr_ptr <= commit_ptr;
          state  <= in_msg.eop ? S_IDLE : S_DROP;
        end else begin
          wr_ptr <= base_ptr + 1'b1;
          if (in_msg.eop) begin
            commit_ptr <= base_ptr + 1'b1;
            state      <= S_IDLE;
          end else begin
            state <= S_WRITE;
          end
        end
      end else if (in_fire && in_msg.eop && state == S_DROP) begin
        state <= S_IDLE;
      end
    end
  end

`ifdef AVALON_MSG_BUFFER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      msgs_passed_cnt  <= '0;
      msgs_dropped_cnt <= '0;
    end else begin
      if (read_eop && msgs_passed_cnt != 32'hFFFF_FFFF) begin
        msgs_passed_cnt <= msgs_passed_cnt + 32'd1;
      end
      if (drop_indi && msgs_dropped_cnt != 32'hFFFF_FFFF) begin
        msgs_dropped_cnt <= msgs_dropped_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: doc/avalon_msg_buffer.md
Name: avalon_msg_buffer

Overview:
Store-and-forward message buffer placed directly downstream of avalon_enforcer. It consumes the enforced Avalon-ST message stream and holds each message until its eop has been stored. Only complete messages are released to the next stage. A message that does not fit is dropped whole, so the output never carries a partial message and a long upstream message can never deadlock the buffer.

Parameters:
DATA_WIDTH_IN_BYTES, 16, data bus width in bytes; empty width = $clog2(DATA_WIDTH_IN_BYTES)
DEPTH, 64, buffer depth in beats; must be a power of 2, >= 2

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
in_msg  avalon_st_if.slave  DATA_WIDTH_IN_BYTES  enforced message stream (data, valid, sop, eop, empty, rdy)
out_msg  avalon_st_if.master  DATA_WIDTH_IN_BYTES  buffered complete-message stream
drop_indi  output  1  one-cycle pulse when a message is discarded
msg_count  output  $clog2(DEPTH)+1  number of complete messages currently held

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high on rst.
- Reset values: out_msg.valid=0, drop_indi=0, msg_count=0. All pointers = 0, in_packet=0, dropping=0. Stored contents are discarded.
- in_msg.rdy = ~rst, combinational. The buffer never backpressures; overflow is handled by dropping.
- Storage: a register array of DEPTH entries {data, sop, eop, empty}.
- Pointers are $clog2(DEPTH)+1 bits wide and wrap naturally: wr_ptr, commit_ptr, rd_ptr. fill = wr_ptr - rd_ptr.
- Accepted beat = in_msg.valid & in_msg.rdy. Input state machine:
  - IDLE: a beat without sop is discarded silently. A beat with sop writes at commit_ptr, sets wr_ptr = commit_ptr+1 and enters WRITE. If that beat also has eop, it commits in the same edge and stays IDLE.
  - WRITE: each beat writes at wr_ptr and increments wr_ptr.
  - WRITE, beat with eop and no overflow: commit_ptr <= wr_ptr+1, msg_count +1, return to IDLE.
  - WRITE, sop seen again: the partial message is discarded (wr_ptr <= commit_ptr) and drop_indi pulses. The new beat is written as the start of a new message.
  - Overflow: an accepted beat while fill == DEPTH triggers wr_ptr <= commit_ptr, drop_indi pulses, and the state goes to DROP.
  - DROP: discard beats until the eop beat, then return to IDLE. A sop in DROP starts a new message as in IDLE.
- drop_indi is registered: it is high in the cycle after the triggering edge, for exactly one cycle per dropped message.
- Output side:
  - out_msg.valid = (rd_ptr != commit_ptr).
  - out_msg.{data, sop, eop, empty} = mem[rd_ptr] (asynchronous read).
  - rd_ptr increments on out_msg.valid & out_msg.rdy.
  - msg_count -1 when the accepted output beat has eop.
- Latency: if the eop beat is accepted at edge k, out_msg.valid is high in the cycle after edge k. Beats stream back-to-back while out_msg.rdy=1.
- Simultaneous commit and eop read in one cycle: msg_count is unchanged.
- Never-fitting message (longer than DEPTH): dropped. Subsequent messages are unaffected.
- rst high mid-message: the in-flight message and all stored messages are lost. out_msg.valid=0 in the cycle after the reset edge.

Optional Feature:
AVALON_MSG_BUFFER_STATS_EN.
- Defined: adds outputs msgs_passed_cnt[31:0] and msgs_dropped_cnt[31:0].
  - msgs_passed_cnt increments on each accepted output eop beat.
  - msgs_dropped_cnt increments on each drop_indi pulse.
  - Both saturate at 32'hFFFF_FFFF and reset to 0.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

Test Plan:
- Test 1, single message passthrough:
  - Stimulus: reset; 4-beat message (sop on beat 0, eop on beat 3, empty=5); out rdy=1.
  - Response: valid high the cycle after the eop edge; 4 back-to-back beats with identical data/sop/eop/empty; msg_count goes 1 then 0.
- Test 2, overflow drop (DEPTH=8):
  - Stimulus: out rdy=0; two 3-beat messages, then a 4-beat third message; then out rdy=1.
  - Response: the third message overflows at its 3rd beat (fill=8); one drop_indi pulse; msg_count=2; exactly 6 beats output.
- Test 3, message longer than the buffer (DEPTH=8):
  - Stimulus: empty buffer, out rdy=1; 10-beat message, then a 2-beat message.
  - Response: first message dropped with no output and one drop_indi pulse; the 2-beat message is output intact; no deadlock.
- Test 4, simultaneous commit and read:
  - Stimulus: a single-beat sop+eop message is accepted in the same cycle the previous message's eop beat is read.
  - Response: msg_count stays 1; both messages are output in order.
- Test 5, sop mid-message:
  - Stimulus: sop on beat 2 of a message in progress.
  - Response: the partial message is discarded; drop_indi pulses; the new message is output intact.
- Test 6, reset mid-operation and statistics:
  - Stimulus: rst asserted while 2 messages are stored; then one 2-beat message.
  - Response: out valid=0 after the reset edge; only the new message is output.
  - With AVALON_MSG_BUFFER_STATS_EN: msgs_passed_cnt=1, msgs_dropped_cnt=0.
